hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV64 core.
- Drives the flush/stall controls (FlushE, StallF, StallD, FlushD, StallE, StallM, FlushW) into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Consumes their execute/memory/writeback destination and control fields and produces the EX-stage forwarding selects.
- Holds a memory-wait FSM with a timeout watchdog so a slow data memory freezes the pipeline cleanly.

Parameters:
MEM_TIMEOUT, 255, wait cycles with MemReqM high and MemReadyM low before err_o sets (1..255)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
Rs1D  in  5  decode-stage rs1
Rs2D  in  5  decode-stage rs2
Rs1E  in  5  execute-stage rs1
Rs2E  in  5  execute-stage rs2
RdE  in  5  execute-stage rd
ResultSrcE  in  2  execute result source; 2'b01 = load
PCSrcE  in  2  execute redirect; nonzero = taken branch/JAL/JALR
RdM  in  5  memory-stage rd
RegWriteM  in  1  memory-stage write enable
RdW  in  5  writeback-stage rd
RegWriteW  in  1  writeback-stage write enable
MemReqM  in  1  load/store in memory stage
MemReadyM  in  1  data memory completes access this cycle
StallF, StallD, StallE, StallM  out  1  hold the respective stage register
FlushD, FlushE, FlushW  out  1  zero the respective stage register next edge
ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 MEM ALU result
err_o  out  1  sticky memory-timeout flag

Behaviour:
- State: RUN or MEM_WAIT, plus wait counter wcnt[7:0] and err_o. All reset asynchronously to RUN / 0 / 0.
- Outputs are combinational from state and inputs. While rst is high, all stall/flush outputs are 0 and both forwards are 00.
- Forwarding (independent of state):
  - ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - ForwardBE is identical using Rs2E.
  - MEM has priority over WB; x0 is never forwarded.
- memwait = MemReqM && !MemReadyM.
- Priority per cycle (highest first):
  1. memwait: StallF=StallD=StallE=StallM=1, FlushW=1. All other flushes are 0; the redirect and load-use checks are suppressed, because E is frozen and re-evaluates after the wait.
  2. redirect (PCSrcE!=0): FlushD=FlushE=1, StallF=StallD=0. The redirect wins over a simultaneous load-use.
  3. load-use (ResultSrcE==01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)): StallF=StallD=1, FlushE=1. This lasts exactly one cycle.
  4. Otherwise all controls are 0.
- FSM transitions:
  - RUN -> MEM_WAIT when memwait; wcnt <= 1.
  - MEM_WAIT stays while memwait; wcnt increments and saturates at 255.
  - When wcnt == MEM_TIMEOUT, err_o <= 1. err_o is sticky until reset; the pipeline keeps waiting.
  - MEM_WAIT -> RUN the cycle MemReadyM is high: outputs released that cycle, wcnt <= 0.
  - MemReqM dropping while in MEM_WAIT also returns to RUN.
- A zero-wait access (MemReqM && MemReadyM) never leaves RUN.
- Reset mid-wait: immediate return to RUN, stalls released, err_o cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, three extra outputs exist:
  - stall_cnt[CNT_W-1:0]: +1 per cycle with StallF=1.
  - flush_cnt[CNT_W-1:0]: +1 per cycle with redirect-caused FlushE.
  - lu_cnt[CNT_W-1:0]: +1 per load-use bubble.
  - All wrap at 2^CNT_W and reset to 0.
- When undefined, the ports and counters are absent and no other behaviour changes.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_LOAD=2'b01.
  - The state encoding (RUN=1'b0, MEM_WAIT=1'b1).
- One sub-module, fwd_sel: the combinational forwarding comparator, instantiated twice (A and B operands).
- The FSM, wait counter and perf counters stay in hazard_ctrl.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; then RegWriteM=0 -> ForwardAE=01.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; with RdE=0 -> no stall.
- Load-use plus PCSrcE=01 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, MemReadyM=0 for 3 cycles, then ready -> all stalls and FlushW high for 3 cycles, released on the ready cycle; PCSrcE=10 during the wait produces no flush.
- MEM_TIMEOUT=4, wait held 10 cycles -> err_o rises after 4 wait cycles and stays high after ready; assert rst -> err_o=0 and state RUN asynchronously.
- With HAZARD_PERF_CNT_EN: 2 load-use bubbles, 1 redirect, 3-cycle mem wait -> lu_cnt=2, flush_cnt=1, stall_cnt=5.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard/stall controller.
// Forward selects, load result source and memory-wait FSM states.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forwarding comparator.
// MEM result beats WB result; x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_m = reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e);
    hit_w = reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e);
    fwd   = FWD_RF;
    if (hit_m)      fwd = FWD_MEM;
    else if (hit_w) fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller with memory-wait FSM and timeout watchdog.
// Optional perf counters (stall/flush/load-use) under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [1:0] ResultSrcE,
  input  logic [1:0] PCSrcE,
  input  logic [4:0] RdM,
  input  logic       RegWriteM,
  input  logic [4:0] RdW,
  input  logic       RegWriteW,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt,
`endif
  output logic       err_o
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
  end

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;

  logic       memwait;
  logic       redirect;
  logic       load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  fwd_sel u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  always_comb begin
    memwait  = MemReqM && !MemReadyM;
    redirect = PCSrcE != 2'b00;
    load_use = (ResultSrcE == RES_LOAD) && (RdE != 5'd0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = rst ? FWD_RF : fwd_a;
    ForwardBE = rst ? FWD_RF : fwd_b;
    // E is frozen during a wait, so redirect/load-use are re-judged after it
    if (rst) begin
      StallF = 1'b0;
    end else if (memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (redirect) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (memwait) begin
          state_d = MEM_WAIT;
          wcnt_d  = 8'd1;
        end else begin
          wcnt_d  = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          if (wcnt_q != 8'hff) wcnt_d = wcnt_q + 8'd1;
        end else begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase
    if (memwait && (wcnt_d == TIMEOUT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, StallF};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, FlushD};
    lu_cnt_d    = lu_cnt_q + {{(CNT_W-1){1'b0}}, StallF && !StallE};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random
// stimulus against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
  logic [1:0] ResultSrcE = '0, PCSrcE = '0;
  logic [4:0] RdM = '0, RdW = '0;
  logic       RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic       MemReqM = 1'b0, MemReadyM = 1'b0;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, lu_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lu_cnt(lu_cnt),
`endif
    .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  // model state: consecutive waiting cycles, sticky error, event tallies
  int n_wait = 0;
  bit err_m = 1'b0;
  int m_stall = 0, m_flush = 0, m_lu = 0;

  logic [10:0] act_v;
  assign act_v = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                  ForwardAE, ForwardBE};

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB}
  function automatic logic [10:0] exp_v();
    logic [6:0] c;
    bit waiting, redir, lu;
    if (rst) return 11'd0;
    waiting = MemReqM && !MemReadyM;
    redir   = PCSrcE != 0;
    lu      = ResultSrcE == 2'd1 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (waiting)    c = 7'b1111001;
    else if (redir) c = 7'b0000110;
    else if (lu)    c = 7'b1100010;
    else            c = 7'b0000000;
    return {c, fwd_of(Rs1E), fwd_of(Rs2E)};
  endfunction

  task automatic tick();
    logic [10:0] e;
    e = exp_v();
    if (rst) begin
      n_wait = 0; err_m = 1'b0;
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (MemReqM && !MemReadyM) begin
        n_wait++;
        if (n_wait >= TO) err_m = 1'b1;
      end else begin
        n_wait = 0;
      end
      if (e[10]) m_stall++;
      if (e[6]) m_flush++;
      if (e[10] && !e[8]) m_lu++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    ResultSrcE = 0; PCSrcE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    MemReqM = ($urandom_range(0, 2) == 0);
    MemReadyM = 1'($urandom);
  endtask

  task automatic test_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 2'd1;
    RegWriteM = 1; RdM = 3; Rs1E = 3;
    @(negedge clk);
    checks++;
    if (act_v !== 11'd0) begin
      errors++; $display("FAIL reset_ctrl act=%b exp=%b", act_v, 11'd0);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL reset_err act=%b exp=0", err_o);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward();
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_mem act=%b/%b exp=10/00", ForwardAE, ForwardBE);
    end
    tick();
    RegWriteM = 0;
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_wb act=%b exp=01", ForwardAE);
    end
    tick();
    RdW = 0; Rs1E = 0; Rs2E = 0;
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0 act=%b/%b exp=00/00", ForwardAE, ForwardBE);
    end
    tick();
    for (int i = 0; i < 30; i++) begin
      rand_inputs();
      MemReqM = 0; PCSrcE = 0; ResultSrcE = 0;
      @(negedge clk);
      checks++;
      if (act_v !== exp_v()) begin
        errors++; $display("FAIL fwd_rand act=%b exp=%b", act_v, exp_v());
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 2;
    @(negedge clk);
    checks++;
    if (act_v !== 11'b1100010_00_00) begin
      errors++; $display("FAIL lu_stall act=%b exp=%b", act_v, 11'b1100010_00_00);
    end
    tick();
    // bubble now in E: load has moved on
    ResultSrcE = 2'b00; RdE = 0;
    @(negedge clk);
    checks++;
    if (act_v !== 11'd0) begin
      errors++; $display("FAIL lu_one_cycle act=%b exp=%b", act_v, 11'd0);
    end
    tick();
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
    @(negedge clk);
    checks++;
    if (act_v !== 11'd0) begin
      errors++; $display("FAIL lu_x0 act=%b exp=%b", act_v, 11'd0);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_redirect_vs_lu();
    ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; PCSrcE = 2'b01;
    @(negedge clk);
    checks++;
    if (act_v !== 11'b0000110_00_00) begin
      errors++; $display("FAIL redir_wins act=%b exp=%b", act_v, 11'b0000110_00_00);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      MemReqM = 1; MemReadyM = 0; PCSrcE = 2'b10;
      ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
      @(negedge clk);
      checks++;
      if (act_v !== 11'b1111001_00_00) begin
        errors++;
        $display("FAIL wait_cyc%0d act=%b exp=%b", i, act_v, 11'b1111001_00_00);
      end
      tick();
    end
    clear_inputs();
    MemReqM = 1; MemReadyM = 1;
    @(negedge clk);
    checks++;
    if (act_v !== 11'd0) begin
      errors++; $display("FAIL wait_release act=%b exp=%b", act_v, 11'd0);
    end
    tick();
    clear_inputs();
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL wait_no_err act=%b exp=0", err_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      MemReqM = 1; MemReadyM = 0;
      tick();
      checks++;
      if (err_o !== (i >= TO) || err_o !== err_m) begin
        errors++;
        $display("FAIL timeout_w%0d act=%b exp=%b", i, err_o, (i >= TO));
      end
    end
    MemReadyM = 1;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL err_sticky act=%b exp=1", err_o);
    end
    // asynchronous reset in the middle of a wait
    MemReqM = 1; MemReadyM = 0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_wait = 0; err_m = 1'b0;
    m_stall = 0; m_flush = 0; m_lu = 0;
    checks++;
    if (err_o !== 1'b0 || act_v !== 11'd0) begin
      errors++;
      $display("FAIL async_rst act=%b/%b exp=0/%b", err_o, act_v, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    // counter restarted from zero: TO-1 waits must not raise err
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++;
      if (err_o !== 1'b0 || err_o !== err_m) begin
        errors++; $display("FAIL rst_wcnt_w%0d act=%b exp=0", i, err_o);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      if (i % 60 < 12) begin
        MemReqM = 1; MemReadyM = 0;
      end
      @(negedge clk);
      checks++;
      if (act_v !== exp_v()) begin
        errors++; $display("FAIL rand_ctrl%0d act=%b exp=%b", i, act_v, exp_v());
      end
      tick();
      checks++;
      if (err_o !== err_m) begin
        errors++; $display("FAIL rand_err%0d act=%b exp=%b", i, err_o, err_m);
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
          lu_cnt !== 16'(m_lu)) begin
        errors++;
        $display("FAIL rand_cnt%0d act=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                 stall_cnt, flush_cnt, lu_cnt, m_stall, m_flush, m_lu);
      end
`endif
    end
    clear_inputs();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      ResultSrcE = 2'b01; RdE = 6; Rs1D = 6;
      tick();
      clear_inputs();
      tick();
    end
    PCSrcE = 2'b11;
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      MemReqM = 1; MemReadyM = 0;
      tick();
    end
    MemReadyM = 1;
    tick();
    clear_inputs();
    checks++;
    if (lu_cnt !== 16'd2 || flush_cnt !== 16'd1 || stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL perf_cnt act=%0d/%0d/%0d exp=2/1/5", lu_cnt, flush_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect_vs_lu();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
